// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + RoB tag).
// Define COMMIT_BYPASS_EN to forward a matching same-cycle commit onto the read ports.
module reg_status_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int REG_W = 5,
  parameter int ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  output logic [XLEN-1:0]  vj,
  output logic [XLEN-1:0]  vk,
  output logic [ROB_W-1:0] qj,
  output logic [ROB_W-1:0] qk,
  output logic             qj_busy,
  output logic             qk_busy,
  input  logic             issue_en,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [ROB_W-1:0] issue_tag,
  input  logic             commit_en,
  input  logic [REG_W-1:0] commit_rd,
  input  logic [ROB_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_data
);

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic             busy;
    logic [ROB_W-1:0] tag;
  } rd_port_t;

  logic [XLEN-1:0]  r_data [NREG];
  logic [ROB_W-1:0] r_tag  [NREG];
  logic [NREG-1:0]  r_busy;

  logic     w_commit_ok;
  logic     w_issue_ok;
  rd_port_t w_rd1;
  rd_port_t w_rd2;

  // Index 0 and indices past the file both behave as the hardwired zero register.
  function automatic logic idx_ok(input logic [REG_W-1:0] idx);
    return (idx != '0) && (32'(idx) < NREG);
  endfunction

  assign w_commit_ok = commit_en && idx_ok(commit_rd);
  assign w_issue_ok  = issue_en && !clear_in && idx_ok(issue_rd);

  function automatic rd_port_t read_port(input logic [REG_W-1:0] idx);
    rd_port_t p;
    p = '0;
    if (idx_ok(idx)) begin
      p.value = r_data[idx];
      p.busy  = r_busy[idx];
      p.tag   = r_busy[idx] ? r_tag[idx] : '0;
`ifdef COMMIT_BYPASS_EN
      if (w_commit_ok && commit_rd == idx && r_busy[idx] && r_tag[idx] == commit_tag) begin
        p.value = commit_data;
        p.busy  = 1'b0;
        p.tag   = '0;
      end
`endif
    end
    return p;
  endfunction

  // NOTE: every always_comb output is given a full value on each pass, so no latch is inferred.
  always_comb begin
    w_rd1 = read_port(rs1_id);
    w_rd2 = read_port(rs2_id);
  end

  assign vj      = w_rd1.value;
  assign qj      = w_rd1.tag;
  assign qj_busy = w_rd1.busy;
  assign vk      = w_rd2.value;
  assign qk      = w_rd2.tag;
  assign qk_busy = w_rd2.busy;

  // NOTE: the data array is reset too, because reads must return 0 for every register after reset.
  // NOTE: non-blocking assignments throughout; later writes to the same bit win, giving the
  //       priority commit < clear < issue without extra muxing.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_busy <= '0;
    end else if (rdy_in) begin
      for (int i = 1; i < NREG; i++) begin
        if (w_commit_ok && 32'(commit_rd) == i) begin
          r_data[i] <= commit_data;
          // A stale commit from an older rename must not release a newer one.
          if (r_busy[i] && r_tag[i] == commit_tag) r_busy[i] <= 1'b0;
        end
        if (clear_in) r_busy[i] <= 1'b0;
        if (w_issue_ok && 32'(issue_rd) == i) begin
          r_busy[i] <= 1'b1;
          r_tag[i]  <= issue_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: stimulus pushes expected read responses,
// a negedge monitor pops and compares them.
module tb_reg_status_file;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int ROB_W = 4;

`ifdef COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic             qj_busy;
    logic             qk_busy;
  } resp_t;

  logic             clk_in, rst_in, rdy_in, clear_in;
  logic [REG_W-1:0] rs1_id, rs2_id;
  logic [XLEN-1:0]  vj, vk;
  logic [ROB_W-1:0] qj, qk;
  logic             qj_busy, qk_busy;
  logic             issue_en;
  logic [REG_W-1:0] issue_rd;
  logic [ROB_W-1:0] issue_tag;
  logic             commit_en;
  logic [REG_W-1:0] commit_rd;
  logic [ROB_W-1:0] commit_tag;
  logic [XLEN-1:0]  commit_data;

  reg_status_file #(.XLEN(XLEN), .NREG(NREG), .REG_W(REG_W), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .vj(vj), .vk(vk), .qj(qj), .qk(qk), .qj_busy(qj_busy), .qk_busy(qk_busy),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  resp_t exp_q  [$];
  string name_q [$];
  logic  chk_req = 1'b0;
  int    n_vec   = 0;
  int    n_miss  = 0;

  task automatic check(input string name, input resp_t act, input resp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got vj=%h vk=%h qj=%0d qk=%0d qj_busy=%b qk_busy=%b, want vj=%h vk=%h qj=%0d qk=%0d qj_busy=%b qk_busy=%b",
               name, act.vj, act.vk, act.qj, act.qk, act.qj_busy, act.qk_busy,
               exp.vj, exp.vk, exp.qj, exp.qk, exp.qj_busy, exp.qk_busy);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the state-changing edge.
  always @(negedge clk_in) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL monitor: read strobed with empty scoreboard");
      end else begin
        check(name_q.pop_front(), '{vj, vk, qj, qk, qj_busy, qk_busy}, exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    rst_in = 1'b0;  rdy_in = 1'b1;  clear_in = 1'b0;
    rs1_id = '0;    rs2_id = '0;
    issue_en = 1'b0;  issue_rd = '0;  issue_tag = '0;
    commit_en = 1'b0; commit_rd = '0; commit_tag = '0; commit_data = '0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    chk_req = 1'b0;
    idle();
  endtask

  task automatic expect_rd(input string name, input logic [XLEN-1:0] e_vj, input logic [XLEN-1:0] e_vk,
                           input logic [ROB_W-1:0] e_qj, input logic [ROB_W-1:0] e_qk,
                           input logic e_qjb, input logic e_qkb);
    exp_q.push_back('{e_vj, e_vk, e_qj, e_qk, e_qjb, e_qkb});
    name_q.push_back(name);
    chk_req = 1'b1;
  endtask

  task automatic do_issue(input int rd, input int tag);
    issue_en = 1'b1; issue_rd = REG_W'(rd); issue_tag = ROB_W'(tag);
  endtask

  task automatic do_commit(input int rd, input int tag, input logic [XLEN-1:0] data);
    commit_en = 1'b1; commit_rd = REG_W'(rd); commit_tag = ROB_W'(tag); commit_data = data;
  endtask

  initial begin
    idle();
    rst_in = 1'b1; rdy_in = 1'b0;
    step();
    rst_in = 1'b1;
    step();

    rs1_id = 5; rs2_id = 0;
    expect_rd("reset_read", 0, 0, 0, 0, 0, 0);
    step();

    do_issue(3, 7); rs1_id = 3;
    expect_rd("issue_own_read", 0, 0, 0, 0, 0, 0);
    step();

    rs1_id = 3;
    expect_rd("x3_busy", 0, 0, 7, 0, 1, 0);
    step();

    do_commit(3, 7, 32'hDEAD_BEEF); rs1_id = 3; rs2_id = 3;
    expect_rd("x3_commit_cycle", BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0,
              BYP ? 4'd0 : 4'd7, BYP ? 4'd0 : 4'd7, !BYP, !BYP);
    step();

    rs1_id = 3;
    expect_rd("x3_committed", 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    step();

    do_issue(4, 2); step();
    do_issue(4, 5); step();
    do_commit(4, 2, 32'h11); rs1_id = 4;
    expect_rd("x4_stale_commit_cycle", 0, 0, 5, 0, 1, 0);
    step();

    rs1_id = 4;
    expect_rd("x4_after_stale", 32'h11, 0, 5, 0, 1, 0);
    step();

    do_commit(4, 5, 32'h44); rs1_id = 4;
    expect_rd("x4_match_commit_cycle", BYP ? 32'h44 : 32'h11, 0, BYP ? 4'd0 : 4'd5, 0, !BYP, 0);
    step();

    rs1_id = 4;
    expect_rd("x4_released", 32'h44, 0, 0, 0, 0, 0);
    step();

    do_issue(6, 1); step();
    do_issue(6, 9); do_commit(6, 1, 32'h22); rs1_id = 6;
    expect_rd("x6_issue_commit_cycle", BYP ? 32'h22 : 32'h0, 0, BYP ? 4'd0 : 4'd1, 0, !BYP, 0);
    step();

    rs1_id = 6;
    expect_rd("x6_issue_wins", 32'h22, 0, 9, 0, 1, 0);
    step();

    for (int i = 1; i < NREG; i++) begin
      do_issue(i, i % 16);
      step();
    end
    rs1_id = 31; rs2_id = 17;
    expect_rd("bulk_rename", 0, 0, 15, 1, 1, 1);
    step();

    clear_in = 1'b1; do_issue(8, 3); do_commit(7, 0, 32'h77);
    step();

    rs1_id = 8; rs2_id = 7;
    expect_rd("after_clear", 0, 32'h77, 0, 0, 0, 0);
    step();

    rs1_id = 3; rs2_id = 4;
    expect_rd("data_kept_on_clear", 32'hDEAD_BEEF, 32'h44, 0, 0, 0, 0);
    step();

    do_issue(0, 5); step();
    rs1_id = 0; rs2_id = 6;
    expect_rd("x0_not_renamed", 0, 32'h22, 0, 0, 0, 0);
    step();

    rdy_in = 1'b0; do_issue(10, 2); do_commit(3, 0, 32'h99);
    step();
    rs1_id = 10; rs2_id = 3;
    expect_rd("rdy_low_holds", 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step();

    do_issue(9, 4); step();
    rdy_in = 1'b0; do_commit(9, 4, 32'h55); rs1_id = 9; rs2_id = 9;
    expect_rd("bypass_rdy_low", BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0,
              BYP ? 4'd0 : 4'd4, BYP ? 4'd0 : 4'd4, !BYP, !BYP);
    step();

    rs2_id = 9;
    expect_rd("x9_still_busy", 0, 0, 0, 4, 0, 1);
    step();

    do_commit(9, 4, 32'h55); rs2_id = 9;
    expect_rd("x9_commit_cycle", 0, BYP ? 32'h55 : 32'h0, 0, BYP ? 4'd0 : 4'd4, 0, !BYP);
    step();

    rs2_id = 9;
    expect_rd("x9_committed", 0, 32'h55, 0, 0, 0, 0);
    step();

    rst_in = 1'b1; rdy_in = 1'b0;
    step();
    rs1_id = 3; rs2_id = 9;
    expect_rd("reset_overrides_rdy", 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk_in);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
Parametrised architectural register file with per-register rename status (busy flag plus producing RoB tag) for the Tomasulo out-of-order core.
- Issue reads two source operands combinationally and gets either a value or a RoB dependency tag.
- Issue renames the destination register.
- RoB commit writes results and clears matching dependencies.
- A flush from the RoB on misprediction clears all rename state.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers; register 0 is hardwired zero
REG_W, 5, register index width; must satisfy 2**REG_W >= NREG
ROB_W, 4, RoB tag width; replaces the global `RoB_addr` width for this block

Ports:
clk_in  input  1  clock; all state changes on posedge
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  when 0, state holds; reads still valid
clear_in  input  1  RoB flush; drops all rename state
rs1_id  input  REG_W  source 1 index
rs2_id  input  REG_W  source 2 index
vj  output  XLEN  source 1 value
vk  output  XLEN  source 2 value
qj  output  ROB_W  source 1 producing tag
qk  output  ROB_W  source 2 producing tag
qj_busy  output  1  source 1 waiting on qj
qk_busy  output  1  source 2 waiting on qk
issue_en  input  1  rename destination this cycle
issue_rd  input  REG_W  destination being renamed
issue_tag  input  ROB_W  RoB entry assigned to the instruction
commit_en  input  1  RoB commits a register result
commit_rd  input  REG_W  committed destination
commit_tag  input  ROB_W  RoB entry being committed
commit_data  input  XLEN  committed value

Behaviour:
- Reset (rst_in=1 at posedge): all data=0, busy=0, tag=0. Reset overrides everything, including rdy_in=0.
- After reset, all outputs are 0.
- State per register: data[XLEN], busy, tag[ROB_W]. Register 0 is never written and never busy.
- State updates occur only when rdy_in=1 and rst_in=0; otherwise state holds.
- Commit (commit_en, commit_rd!=0):
  - data[commit_rd] <= commit_data unconditionally.
  - busy[commit_rd] <= 0 only if busy=1 and tag==commit_tag. A stale commit from an older rename leaves busy/tag intact.
- Issue (issue_en, issue_rd!=0, clear_in=0): busy[issue_rd] <= 1; tag[issue_rd] <= issue_tag.
- Issue and commit to the same rd in the same cycle: data is written; issue wins, so busy=1 and tag=issue_tag.
- clear_in=1:
  - All busy <= 0 next cycle. Tags are don't-care.
  - A same-cycle commit still writes data.
  - Same-cycle issue is ignored.
- Read (combinational, per port; rs index x):
  - x==0: value 0, busy 0, tag 0.
  - busy[x]=0: value=data[x], busy 0, tag 0.
  - busy[x]=1: value=data[x] (stale, don't-use), busy 1, tag=tag[x].
- Reads reflect pre-edge state. Same-cycle issue never affects its own reads, so rs==rd is handled correctly.
- Out-of-range index (>=NREG): read as register 0; writes and renames are dropped.
- Latency: commit is visible on reads the cycle after the edge unless bypassed (see Optional Feature).

Optional Feature:
COMMIT_BYPASS_EN
- Defined: read port x sees the same-cycle commit when commit_en=1, commit_rd==x!=0, busy[x]=1 and tag[x]==commit_tag. In that case value=commit_data and busy=0, tag=0. This lets an instruction issue ready in the commit cycle. Bypass applies even if rdy_in=0.
- Also defined: if commit_rd==x but the tag mismatches, or busy[x]=0, the read shows stored state only (no bypass).
- Undefined: reads show stored state only; the dependency resolves one cycle later via the RS/LSB broadcast.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> vj=0, vk=0, qj_busy=0, qk_busy=0.
- Issue rd=3, tag=7; next cycle read rs1=3 -> qj_busy=1, qj=7. Commit rd=3, tag=7, data=0xDEAD_BEEF; next cycle -> qj_busy=0, vj=0xDEADBEEF.
- Rename x4 to tag 2, then to tag 5; commit x4, tag 2, data 0x11 -> data=0x11, busy stays 1, qj=5. Commit tag 5 -> busy=0.
- Same cycle: issue x6 tag 9 and commit x6 tag (prior) 1, data 0x22 -> next cycle busy=1, qj=9; with rs1=6 read that cycle, pre-edge status is shown.
- Rename x1..x31 with tags i%16, then pulse clear_in together with issue x8 tag 3 -> all busy=0, x8 not renamed. Issue x0 -> x0 stays 0 and not busy.
- COMMIT_BYPASS_EN, x9 busy with tag 4, commit x9 tag 4 data 0x55, rs2=9 in the same cycle -> vk=0x55, qk_busy=0 combinationally. Without the macro -> qk_busy=1, qk=4.
